// File: rtl/can_bus_channel_model.sv
// rtl/can_bus_channel_model.sv - clocked CAN wired-AND bus model with per-node delay, fault injection and monitor
//
// Purpose: shared CAN bus between NODES controllers. Each node's TX is delayed by
// its own programmable one-way delay before the wired-AND, and the bus is delayed
// again by the same amount on the way back to that node's RX. Includes a global
// stuck-dominant fault, a per-node disconnect mask, and a bus monitor (idle,
// stuck-dominant, recessive-to-dominant edge count).
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   tx_i         per-node TX (1 = recessive)
//   rx_o         per-node delayed view of the bus
//   bus_o        instantaneous wired-AND bus level
//   dly_i        node n one-way delay at [n*DLY_W +: DLY_W], clamped to MAX_DELAY
//   disc_mask_i  1 = node disconnected (TX treated as recessive)
//   force_dom_i  bus forced dominant while high
//   bit_time_i   clk_i cycles per nominal bit (0 treated as 1)
//   clr_i        clears edge_cnt_o (priority over a same-cycle edge)
//   idle_o       11 recessive bit times seen
//   stuck_o      STUCK_BITS dominant bit times seen
//   edge_cnt_o   saturating recessive-to-dominant edge count

module can_bus_channel_model #(
  parameter int NODES      = 3,
  parameter int MAX_DELAY  = 16,
  parameter int DLY_W      = 5,
  parameter int STUCK_BITS = 13
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NODES-1:0]       tx_i,
  output logic [NODES-1:0]       rx_o,
  output logic                   bus_o,
  input  logic [NODES*DLY_W-1:0] dly_i,
  input  logic [NODES-1:0]       disc_mask_i,
  input  logic                   force_dom_i,
  input  logic [15:0]            bit_time_i,
  input  logic                   clr_i,
  output logic                   idle_o,
  output logic                   stuck_o,
  output logic [15:0]            edge_cnt_o
);

  // Bit k of a line holds the input sampled k+1 cycles ago.
  logic [MAX_DELAY-1:0] tx_sr_q [NODES];
  logic [MAX_DELAY-1:0] tx_sr_d [NODES];
  logic [MAX_DELAY-1:0] rx_sr_q [NODES];
  logic [MAX_DELAY-1:0] rx_sr_d [NODES];

  logic [DLY_W-1:0] dly_eff [NODES];
  logic [NODES-1:0] txd;
  logic [NODES-1:0] rxd;
  logic             bus_raw;

  logic [20:0] rec_cnt_q, rec_cnt_d;
  logic [20:0] dom_cnt_q, dom_cnt_d;
  logic        bus_q, bus_d;
  logic        idle_q, idle_d;
  logic        stuck_q, stuck_d;
  logic [15:0] edge_cnt_q, edge_cnt_d;

  logic [15:0] bt;
  logic [20:0] t_idle;
  logic [20:0] t_stuck;
  logic [21:0] rec_inc;
  logic [21:0] dom_inc;

  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      if (dly_i[n*DLY_W +: DLY_W] > DLY_W'(MAX_DELAY)) begin
        dly_eff[n] = DLY_W'(MAX_DELAY);
      end else begin
        dly_eff[n] = dly_i[n*DLY_W +: DLY_W];
      end
    end
  end

  // Tap select; delay 0 falls through to the live input.
  always_comb begin
    txd = tx_i;
    for (int n = 0; n < NODES; n++) begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        if (dly_eff[n] == DLY_W'(k)) begin
          txd[n] = tx_sr_q[n][k-1];
        end
      end
    end
    bus_raw = ~force_dom_i & (&(txd | disc_mask_i));
  end

  assign bus_o = rst_i | bus_raw;

  always_comb begin
    rxd = {NODES{bus_o}};
    for (int n = 0; n < NODES; n++) begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        if (dly_eff[n] == DLY_W'(k)) begin
          rxd[n] = rx_sr_q[n][k-1];
        end
      end
    end
  end

  assign rx_o = rst_i ? {NODES{1'b1}} : rxd;

  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      tx_sr_d[n]    = tx_sr_q[n];
      rx_sr_d[n]    = rx_sr_q[n];
      tx_sr_d[n][0] = tx_i[n];
      rx_sr_d[n][0] = bus_o;
      for (int k = 1; k < MAX_DELAY; k++) begin
        tx_sr_d[n][k] = tx_sr_q[n][k-1];
        rx_sr_d[n][k] = rx_sr_q[n][k-1];
      end
    end
  end

  always_comb begin
    bt      = (bit_time_i == 16'd0) ? 16'd1 : bit_time_i;
    t_idle  = 21'(bt) * 21'd11;
    t_stuck = 21'(bt) * 21'(STUCK_BITS);
    rec_inc = {1'b0, rec_cnt_q} + 22'd1;
    dom_inc = {1'b0, dom_cnt_q} + 22'd1;

    rec_cnt_d = '0;
    dom_cnt_d = '0;
    if (bus_o) begin
      rec_cnt_d = (rec_cnt_q == '1) ? rec_cnt_q : rec_inc[20:0];
    end else begin
      dom_cnt_d = (dom_cnt_q == '1) ? dom_cnt_q : dom_inc[20:0];
    end
    idle_d  = bus_o & (rec_inc >= {1'b0, t_idle});
    stuck_d = ~bus_o & (dom_inc >= {1'b0, t_stuck});

    bus_d      = bus_o;
    edge_cnt_d = edge_cnt_q;
    if (clr_i) begin
      edge_cnt_d = '0;
    end else if (bus_q && !bus_o && edge_cnt_q != 16'hFFFF) begin
      edge_cnt_d = edge_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NODES; n++) begin
        tx_sr_q[n] <= '1;
        rx_sr_q[n] <= '1;
      end
      rec_cnt_q  <= '0;
      dom_cnt_q  <= '0;
      bus_q      <= 1'b1;
      idle_q     <= 1'b0;
      stuck_q    <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      for (int n = 0; n < NODES; n++) begin
        tx_sr_q[n] <= tx_sr_d[n];
        rx_sr_q[n] <= rx_sr_d[n];
      end
      rec_cnt_q  <= rec_cnt_d;
      dom_cnt_q  <= dom_cnt_d;
      bus_q      <= bus_d;
      idle_q     <= idle_d;
      stuck_q    <= stuck_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign idle_o     = idle_q;
  assign stuck_o    = stuck_q;
  assign edge_cnt_o = edge_cnt_q;

endmodule
